// File: rtl/btn_mode_ctrl.sv
// btn_mode_ctrl: turns raw push-buttons into a debounced, edge-detected
// 2-bit mode code. Each button is synchronized (2 flops) and debounced;
// press pulses then step, clear, or freeze the mode register.
// Button map: [0]=up, [1]=down, [2]=clear, [3]=freeze toggle.
module btn_mode_ctrl #(
  parameter int          N_BTN           = 4,
  parameter int          DEBOUNCE_CYCLES = 2500000,
  parameter int          CNT_W           = 22,
  parameter logic [1:0]  MODE_RST        = 2'd0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [1:0]       mode,
  output logic             mode_chg,
  output logic             frozen
);

  // Terminal count: a level change is accepted on the cycle the counter
  // has already seen DEBOUNCE_CYCLES-1 consecutive differing samples.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_BTN-1:0] r_s1;
  logic [N_BTN-1:0] r_s2;
  logic [N_BTN-1:0] w_level;
  logic [N_BTN-1:0] r_prev_level;
  logic [N_BTN-1:0] r_press;
  logic [1:0]       r_mode;
  logic [1:0]       w_mode_next;
  logic             r_mode_chg;
  logic             r_frozen;

  // Two-flop synchronizer for the asynchronous button inputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= btn;
      r_s2 <= r_s1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_BTN; gi++) begin : g_debounce
      logic [CNT_W-1:0] r_cnt;
      logic             r_lvl;

      // Debounce: count consecutive cycles where s2 differs from the
      // accepted level; any return to the accepted level restarts the count
      always_ff @(posedge clk) begin
        if (rst) begin
          r_cnt <= '0;
          r_lvl <= 1'b0;
        end else if (r_s2[gi] == r_lvl) begin
          r_cnt <= '0;
        end else if (r_cnt == CNT_MAX) begin
          r_lvl <= r_s2[gi];
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end

      assign w_level[gi] = r_lvl;
    end
  endgenerate

  // Rising-edge detect on the debounced level: one pulse per press
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev_level <= '0;
      r_press      <= '0;
    end else begin
      r_prev_level <= w_level;
      r_press      <= w_level & ~r_prev_level;
    end
  end

  // Next mode: clear beats up beats down; nothing moves while frozen.
  // The freeze toggle in the same cycle does not affect this decision.
  always_comb begin
    w_mode_next = r_mode;
    if (!r_frozen) begin
      if (r_press[2]) begin
        w_mode_next = MODE_RST;
      end else if (r_press[0]) begin
        w_mode_next = r_mode + 2'd1;
      end else if (r_press[1]) begin
        w_mode_next = r_mode - 2'd1;
      end
    end
  end

  // Mode, change pulse and freeze state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode     <= MODE_RST;
      r_mode_chg <= 1'b0;
      r_frozen   <= 1'b0;
    end else begin
      r_mode     <= w_mode_next;
      r_mode_chg <= (w_mode_next != r_mode);
      r_frozen   <= r_frozen ^ r_press[3];
    end
  end

  assign btn_level = w_level;
  assign btn_press = r_press;
  assign mode      = r_mode;
  assign mode_chg  = r_mode_chg;
  assign frozen    = r_frozen;

endmodule

// File: tb/tb_btn_mode_ctrl.sv
// Scoreboard bench for btn_mode_ctrl with a short debounce window.
// Stimulus pushes expected output events (with the cycle they must appear);
// a monitor pops and compares whenever the DUT shows a press pulse,
// a mode_chg pulse or a frozen transition.
module tb_btn_mode_ctrl;

  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] btn = 4'b0000;
  logic [3:0] btn_level;
  logic [3:0] btn_press;
  logic [1:0] mode;
  logic       mode_chg;
  logic       frozen;

  typedef struct packed {
    int unsigned cyc;
    logic [3:0]  press;
    logic [3:0]  level;
    logic [1:0]  mode;
    logic        chg;
    logic        fz;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc    = 0;
  logic [1:0]  cur_mode = 2'd0;
  logic        cur_fz   = 1'b0;

  btn_mode_ctrl #(
    .N_BTN(4), .DEBOUNCE_CYCLES(DB), .CNT_W(3), .MODE_RST(2'd0)
  ) dut (
    .clk(clk), .rst(rst), .btn(btn), .btn_level(btn_level),
    .btn_press(btn_press), .mode(mode), .mode_chg(mode_chg), .frozen(frozen)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end else begin
      $display("ok   %s = %0d (cycle %0d)", name, act, cyc);
    end
  endtask

  task automatic monitor();
    exp_t e;
    logic prev_fz = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && (btn_press != 4'b0 || mode_chg || frozen !== prev_fz)) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event cyc=%0d press=%b level=%b mode=%0d chg=%b frozen=%b, expected no event",
                   cyc, btn_press, btn_level, mode, mode_chg, frozen);
        end else begin
          e = q.pop_front();
          if (e.cyc != cyc || e.press !== btn_press || e.level !== btn_level ||
              e.mode !== mode || e.chg !== mode_chg || e.fz !== frozen) begin
            errors++;
            $display("FAIL event: got cyc=%0d press=%b level=%b mode=%0d chg=%b frozen=%b expected cyc=%0d press=%b level=%b mode=%0d chg=%b frozen=%b",
                     cyc, btn_press, btn_level, mode, mode_chg, frozen,
                     e.cyc, e.press, e.level, e.mode, e.chg, e.fz);
          end else begin
            $display("ok   event cyc=%0d press=%b level=%b mode=%0d chg=%b frozen=%b",
                     cyc, btn_press, btn_level, mode, mode_chg, frozen);
          end
        end
      end
      prev_fz = frozen;
    end
  endtask

  // Queue the events one button press must produce: press pulse 7 edges
  // after btn is driven (2 sync + 4 debounce + 1 edge), then mode/frozen
  // update one edge later if anything visible changes.
  task automatic push_press(input logic [3:0] mask, input logic [1:0] m,
                            input logic c, input logic f);
    exp_t e;
    e.cyc = cyc + 7; e.press = mask; e.level = mask;
    e.mode = cur_mode; e.chg = 1'b0; e.fz = cur_fz;
    q.push_back(e);
    if (c || f != cur_fz) begin
      e.cyc = cyc + 8; e.press = 4'b0; e.level = mask;
      e.mode = m; e.chg = c; e.fz = f;
      q.push_back(e);
    end
    cur_mode = m;
    cur_fz   = f;
  endtask

  // Hold a button pattern long enough to be accepted, then release and
  // wait for the release to settle (no events expected on release).
  task automatic do_vec(input logic [3:0] mask, input logic [1:0] m,
                        input logic c, input logic f, input bit chk_lat);
    push_press(mask, m, c, f);
    btn = mask;
    if (chk_lat) begin
      repeat (2 + DB - 1) @(negedge clk);
      check("level_before_accept", int'(btn_level[0]), 0);
      @(negedge clk);
      check("level_at_accept", int'(btn_level[0]), 1);
      repeat (10 - 2 - DB) @(negedge clk);
    end else begin
      repeat (10) @(negedge clk);
    end
    btn = 4'b0000;
    repeat (12) @(negedge clk);
  endtask

  typedef struct packed {
    logic [3:0] mask;
    logic [1:0] m;
    logic       c;
    logic       f;
  } vec_t;

  // Hand-computed expected mode / mode_chg / frozen after each press
  vec_t vecs [16] = '{
    '{4'b0001, 2'd3, 1'b1, 1'b0},  // up 2->3
    '{4'b0001, 2'd0, 1'b1, 1'b0},  // up wraps 3->0
    '{4'b0010, 2'd3, 1'b1, 1'b0},  // down wraps 0->3
    '{4'b0010, 2'd2, 1'b1, 1'b0},  // down 3->2
    '{4'b0111, 2'd0, 1'b1, 1'b0},  // clear beats up and down
    '{4'b0011, 2'd1, 1'b1, 1'b0},  // up beats down
    '{4'b0100, 2'd0, 1'b1, 1'b0},  // clear 1->0
    '{4'b0100, 2'd0, 1'b0, 1'b0},  // clear at reset value: no pulse
    '{4'b1000, 2'd0, 1'b0, 1'b1},  // freeze on
    '{4'b0001, 2'd0, 1'b0, 1'b1},  // ignored while frozen
    '{4'b0001, 2'd0, 1'b0, 1'b1},  // ignored while frozen
    '{4'b1000, 2'd0, 1'b0, 1'b0},  // freeze off
    '{4'b0001, 2'd1, 1'b1, 1'b0},  // up 0->1
    '{4'b1001, 2'd2, 1'b1, 1'b1},  // up uses old frozen=0, then freezes
    '{4'b1000, 2'd2, 1'b0, 1'b0},  // freeze off
    '{4'b0010, 2'd1, 1'b1, 1'b0}   // down 2->1
  };

  logic glitch_level;

  initial begin
    fork
      monitor();
    join_none

    // Reset for two cycles, then check reset values
    repeat (2) @(negedge clk);
    check("rst_btn_level", int'(btn_level), 0);
    check("rst_btn_press", int'(btn_press), 0);
    check("rst_mode", int'(mode), 0);
    check("rst_mode_chg", int'(mode_chg), 0);
    check("rst_frozen", int'(frozen), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // First press with latency check: mode 0->1
    do_vec(4'b0001, 2'd1, 1'b1, 1'b0, 1'b1);

    // Glitchy button never reaches acceptance
    glitch_level = 1'b0;
    btn = 4'b0001;
    repeat (3) begin @(negedge clk); glitch_level |= btn_level[0]; end
    btn = 4'b0000;
    repeat (1) begin @(negedge clk); glitch_level |= btn_level[0]; end
    btn = 4'b0001;
    repeat (3) begin @(negedge clk); glitch_level |= btn_level[0]; end
    btn = 4'b0000;
    repeat (12) begin @(negedge clk); glitch_level |= btn_level[0]; end
    check("glitch_level", int'(glitch_level), 0);
    check("glitch_mode", int'(mode), 1);

    // Stable press after the glitch is accepted: mode 1->2
    do_vec(4'b0001, 2'd2, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 16; i++) begin
      do_vec(vecs[i].mask, vecs[i].m, vecs[i].c, vecs[i].f, 1'b0);
    end
    check("mode_before_reset", int'(mode), 1);

    // Reset while btn[0] is mid-debounce (counter at 3 of 4)
    btn = 4'b0001;
    repeat (2 + DB - 1) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_level", int'(btn_level), 0);
    check("midrst_mode", int'(mode), 0);
    check("midrst_frozen", int'(frozen), 0);
    cur_mode = 2'd0;
    cur_fz   = 1'b0;
    push_press(4'b0001, 2'd1, 1'b1, 1'b0);
    rst = 1'b0;
    repeat (2 + DB - 1) @(negedge clk);
    check("postrst_level_before", int'(btn_level[0]), 0);
    @(negedge clk);
    check("postrst_level_at", int'(btn_level[0]), 1);
    repeat (6) @(negedge clk);
    btn = 4'b0000;
    repeat (12) @(negedge clk);
    check("final_mode", int'(mode), 1);

    // Every expected event must have been seen
    check("pending_events", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
